tdm_mux_8x1: RTL and testbench
==============================

TDM_MUX_8X1 -- requirements
Module: tdm_mux_8x1

Interface
REQ-001 Parameter DATA_W, default 8, width of each channel data word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  8  per-channel request; bit k = channel k holds a word.
REQ-005 in_data  input  8*DATA_W  channel k word at bits [k*DATA_W +: DATA_W].
REQ-006 in_last  input  8  per-channel end-of-burst marker, qualified by in_valid[k].
REQ-007 in_ready  output  8  per-channel accept; transfer on k when in_valid[k] & in_ready[k].
REQ-008 out_valid  output  1  out_data/out_sel hold a word.
REQ-009 out_data  output  DATA_W  selected word.
REQ-010 out_sel  output  3  source channel index of out_data, directly usable as a 1x8 demux select downstream.
REQ-011 out_ready  input  1  downstream accept; transfer when out_valid & out_ready.

Function
REQ-012 Output stage is one register slot; slot is free when out_valid==0 or out_ready==1 in the same cycle.
REQ-013 in_ready is combinational, at most one bit set, and zero whenever the slot is not free.
REQ-014 Arbitration: round-robin over requesting channels, search starting at pointer ptr (3 bits), ascending, wrapping 7->0.
REQ-015 Grant g gets in_ready[g]=1; on that edge out_data<=word g, out_sel<=g, out_valid<=1; latency input-transfer to out_valid = 1 cycle.
REQ-016 After each transfer from channel g in state ARB, ptr<=(g+1) mod 8; g=7 sets ptr to 0.
REQ-017 When slot frees with no request, out_valid<=0 next cycle; out_data/out_sel hold last values.
REQ-018 Simultaneous output drain and new input grant in one cycle sustains one word/cycle throughput.
REQ-019 out_valid stays 1 and out_data/out_sel stay stable while out_ready==0.
REQ-020 in_valid deasserting without transfer is tolerated; arbitration re-evaluates every cycle.
REQ-021 FSM states: ARB (free arbitration) and HOLD (burst lock); HOLD is reachable only with the Configuration macro defined.

Reset
REQ-022 rst_n low asynchronously forces out_valid=0, out_data=0, out_sel=0, ptr=0, state=ARB; in_ready=0 while rst_n low.
REQ-023 Reset mid-burst or with a word held discards it; first grant after release starts search at channel 0.

Configuration
REQ-024 Macro TDM_MUX_BURST_LOCK_EN defined: transfer from g with in_last[g]==0 moves ARB->HOLD with lock=g; in HOLD only channel lock may be granted (others in_ready=0) even if lock idles; transfer with in_last[lock]==1 returns to ARB and sets ptr<=(lock+1) mod 8.
REQ-025 Macro undefined: in_last ignored, FSM permanently ARB, every transfer advances ptr per REQ-016.

Structure
REQ-026 Package tdm_mux_pkg holds CH_NUM=8, SEL_W=3, and the state enum {ARB, HOLD}.
REQ-027 Sub-module rr_arb_8: inputs req[7:0], ptr[2:0], enable; outputs one-hot gnt[7:0] and encoded gnt_idx[2:0]; purely combinational.

Verification
REQ-028 After reset, in_valid=8'hFF, out_ready=1 constant -> out_sel sequence 0,1,2,...,7,0 on consecutive cycles, out_valid=1 from cycle 2 onward.
REQ-029 in_valid=8'b1000_0001, ptr=0, out_ready=1 -> grants 0,7,0,7; out_data matches channel words 8'h11/8'h77 resp.
REQ-030 Word 8'hA5 from channel 3 held with out_ready=0 for 5 cycles -> out_valid=1, out_data=8'hA5, out_sel=3 stable, in_ready=0 all 5 cycles.
REQ-031 rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0, out_sel=0 immediately; next grant with in_valid=8'h20 is channel 5 after ptr search from 0.
REQ-032 TDM_MUX_BURST_LOCK_EN defined, channel 2 burst of 3 words (in_last on third), channel 6 requesting throughout -> out_sel 2,2,2,6; without macro -> 2,6,2,6,2.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// Shared constants and FSM state type for the 8:1 TDM multiplexer.
package tdm_mux_pkg;
   localparam int CH_NUM = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } state_t;
endpackage

// File: rtl/rr_arb_8.sv
// Combinational 8-way round-robin arbiter: the first requester at or after ptr
// (ascending, wrapping 7->0) wins.
module rr_arb_8
   import tdm_mux_pkg::*;
(
   input  logic [CH_NUM-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              enable,
   output logic [CH_NUM-1:0] gnt,
   output logic [SEL_W-1:0]  gnt_idx
);

   logic             found;
   logic [SEL_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         // 3-bit addition wraps the search window around channel 7
         idx = ptr + SEL_W'(i);
         if (enable && !found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/tdm_mux_8x1.sv
// 8:1 round-robin TDM multiplexer with a single registered output slot.
// Optional burst locking is enabled with `define TDM_MUX_BURST_LOCK_EN.
module tdm_mux_8x1
   import tdm_mux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CH_NUM-1:0]        in_valid,
   input  logic [CH_NUM*DATA_W-1:0] in_data,
   input  logic [CH_NUM-1:0]        in_last,
   output logic [CH_NUM-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_sel,
   input  logic                     out_ready
);

   state_t            state;
   logic [SEL_W-1:0]  ptr;
   logic [CH_NUM-1:0] req;
   logic [CH_NUM-1:0] gnt;
   logic [SEL_W-1:0]  gnt_idx;
   logic              slot_free;
   logic              xfer;

   assign slot_free = !out_valid || out_ready;

`ifdef TDM_MUX_BURST_LOCK_EN
   logic [SEL_W-1:0] lock;

   // While a burst is locked only the owning channel may compete
   assign req = (state == HOLD) ? (in_valid & (CH_NUM'(1) << lock)) : in_valid;
`else
   logic unused_last;

   assign unused_last = ^in_last;
   assign req         = in_valid;
`endif

   rr_arb_8 u_arb (
      .req     (req),
      .ptr     (ptr),
      .enable  (slot_free),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign in_ready = rst_n ? gnt : '0;
   assign xfer     = |gnt;

   // Output slot register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[gnt_idx*DATA_W +: DATA_W];
         out_sel   <= gnt_idx;
      end else if (slot_free) begin
         out_valid <= 1'b0;
      end
   end

   // Arbitration pointer and burst-lock FSM
`ifdef TDM_MUX_BURST_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB;
         ptr   <= '0;
         lock  <= '0;
      end else if (xfer) begin
         case (state)
            ARB: begin
               ptr <= gnt_idx + SEL_W'(1);
               if (!in_last[gnt_idx]) begin
                  state <= HOLD;
                  lock  <= gnt_idx;
               end
            end
            HOLD: begin
               if (in_last[lock]) begin
                  state <= ARB;
                  ptr   <= lock + SEL_W'(1);
               end
            end
            default: state <= ARB;
         endcase
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB;
         ptr   <= '0;
      end else if (xfer) begin
         state <= ARB;
         ptr   <= gnt_idx + SEL_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Self-checking bench for tdm_mux_8x1: vector table, directed corner cases and
// randomized traffic against a behavioural model.
module tb_tdm_mux_8x1;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    in_valid = '0;
   logic [8*DW-1:0] in_data = '0;
   logic [7:0]    in_last = '0;
   logic [7:0]    in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [2:0]    out_sel;
   logic          out_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   bit       m_valid;
   int       m_sel;
   int       m_data;
   int       m_ptr;
   bit       m_hold;
   int       m_lock;

   typedef struct {
      logic [7:0] iv;
      logic       ordy;
      int         exp_sel;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   tdm_mux_8x1 #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_valid = 0; m_sel = 0; m_data = 0; m_ptr = 0; m_hold = 0; m_lock = 0;
   endfunction

   // Winner = requesting channel with the smallest circular distance from ptr
   function automatic int model_grant(logic [7:0] iv, logic ordy);
      int best = -1;
      int bd = 8;
      if (m_valid && !ordy) return -1;
      if (m_hold) return iv[m_lock] ? m_lock : -1;
      for (int c = 0; c < 8; c++) begin
         if (iv[c] && ((c - m_ptr + 8) % 8) < bd) begin
            bd = (c - m_ptr + 8) % 8;
            best = c;
         end
      end
      return best;
   endfunction

   // One clock cycle: drive, check in_ready, clock, check output slot
   task automatic cycle(input logic [7:0] iv, input logic [8*DW-1:0] id,
                        input logic [7:0] il, input logic ordy);
      int g;
      int exp_rdy;
      in_valid  = iv;
      in_data   = id;
      in_last   = il;
      out_ready = ordy;
      #1;
      g = model_grant(iv, ordy);
      exp_rdy = (g < 0) ? 0 : (1 << g);
      check("in_ready", int'(in_ready), exp_rdy);
      @(posedge clk);
      if (g >= 0) begin
         m_valid = 1;
         m_sel   = g;
         m_data  = int'(id[g*DW +: DW]);
         if (m_hold) begin
            if (il[m_lock]) begin
               m_hold = 0;
               m_ptr  = (m_lock + 1) % 8;
            end
         end else begin
            m_ptr = (g + 1) % 8;
`ifdef TDM_MUX_BURST_LOCK_EN
            if (!il[g]) begin
               m_hold = 1;
               m_lock = g;
            end
`endif
         end
      end else if (!m_valid || ordy) begin
         m_valid = 0;
      end
      #1;
      check("out_valid", int'(out_valid), int'(m_valid));
      check("out_sel", int'(out_sel), m_sel);
      check("out_data", int'(out_data), m_data);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   function automatic logic [8*DW-1:0] rand_data();
      logic [8*DW-1:0] d;
      d = {$urandom, $urandom};
      return d;
   endfunction

   initial begin
      logic [8*DW-1:0] d;
      int exp32[5];
      int cnt2;

      for (int i = 0; i < 9; i++) begin
         vecs[i].iv = 8'hFF;
         vecs[i].ordy = 1'b1;
         vecs[i].exp_sel = i % 8;
         vecs[i].exp_valid = 1'b1;
      end

      // reset state
      model_reset();
      #2;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sel", int'(out_sel), 0);
      check("rst_out_data", int'(out_data), 0);
      in_valid = 8'hFF;
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      do_reset();

      // full-load rotation 0..7,0
      for (int i = 0; i < 9; i++) begin
         cycle(vecs[i].iv, rand_data(), 8'hFF, vecs[i].ordy);
         check("tbl_sel", int'(out_sel), vecs[i].exp_sel);
         check("tbl_valid", int'(out_valid), int'(vecs[i].exp_valid));
      end

      // channels 0 and 7 alternate
      do_reset();
      d = '0;
      d[0*DW +: DW] = 8'h11;
      d[7*DW +: DW] = 8'h77;
      for (int i = 0; i < 4; i++) begin
         cycle(8'b1000_0001, d, 8'hFF, 1'b1);
         check("alt_sel", int'(out_sel), (i % 2) ? 7 : 0);
         check("alt_data", int'(out_data), (i % 2) ? 8'h77 : 8'h11);
      end

      // stall: word held stable while out_ready low
      do_reset();
      d = rand_data();
      d[3*DW +: DW] = 8'hA5;
      cycle(8'b0000_1000, d, 8'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(8'hFF, rand_data(), 8'hFF, 1'b0);
         check("hold_valid", int'(out_valid), 1);
         check("hold_data", int'(out_data), 8'hA5);
         check("hold_sel", int'(out_sel), 3);
         check("hold_ready", int'(in_ready), 0);
      end
      cycle(8'h00, rand_data(), 8'hFF, 1'b1);
      check("drain_valid", int'(out_valid), 0);
      check("drain_data_kept", int'(out_data), 8'hA5);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) cycle(8'hFF, rand_data(), 8'hFF, 1'b1);
      check("pre_rst_valid", int'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", int'(out_valid), 0);
      check("arst_sel", int'(out_sel), 0);
      check("arst_ready", int'(in_ready), 0);
      model_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      cycle(8'h20, rand_data(), 8'hFF, 1'b1);
      check("post_rst_sel", int'(out_sel), 5);

      // channel 2 burst of three words with channel 6 competing
`ifdef TDM_MUX_BURST_LOCK_EN
      exp32 = '{2, 2, 2, 6, 2};
`else
      exp32 = '{2, 6, 2, 6, 2};
`endif
      do_reset();
      cnt2 = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(8'h44, rand_data(), {1'b0, 1'b1, 3'b000, (cnt2 >= 2), 2'b00}, 1'b1);
         check("burst_sel", int'(out_sel), exp32[i]);
         if (out_sel == 3'd2) cnt2++;
      end

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(8'($urandom), rand_data(),
               8'($urandom) | 8'($urandom),
               ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
